// File: rtl/vga_text_fetch.sv
// Text-mode cell fetcher: maps raster coordinates to a character-buffer read
// and presents char/colours/tile coordinates aligned to the pixel generator.
module vga_text_fetch #(
  parameter int COLS         = 40,
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 30,
  parameter int SYNC_DELAY   = 3
) (
  input  logic        pix_clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        vid_active_in,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        cursor_en,
  input  logic [5:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [10:0] buf_addr,
  input  logic [30:0] buf_data,
  output logic [6:0]  char,
  output logic [11:0] char_color,
  output logic [11:0] back_color,
  output logic        vid_active,
  output logic [3:0]  tile_x,
  output logic [3:0]  tile_y,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam logic [6:0] COLS_L      = 7'(COLS);
  localparam logic [5:0] ROWS_L      = 6'(ROWS);
  localparam logic [5:0] BLINK_LAST  = 6'(BLINK_FRAMES - 1);

  logic [5:0]  col;
  logic [4:0]  row;
  logic        cell_ok;
  logic        cursor_hit;
  logic [10:0] addr_next;

  logic        s1_valid;
  logic        s1_hit;
  logic [3:0]  s1_tile_x;
  logic [3:0]  s1_tile_y;

  logic [5:0]  frame_cnt;
  logic        blink_on;
  logic        vsync_prev;
  logic        vsync_fall;

  logic [SYNC_DELAY-1:0] hs_sr;
  logic [SYNC_DELAY-1:0] vs_sr;

  // row*40 built from two shifts so no multiplier is inferred
  always_comb begin
    col        = pix_x[9:4];
    row        = pix_y[8:4];
    cell_ok    = vid_active_in && en && ({1'b0, col} < COLS_L) && ({1'b0, row} < ROWS_L);
    cursor_hit = cursor_en && (col == cursor_col) && (row == cursor_row);
    addr_next  = {1'b0, row, 5'b0} + {3'b0, row, 3'b0} + {5'b0, col};
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_addr  <= '0;
      s1_valid  <= 1'b0;
      s1_hit    <= 1'b0;
      s1_tile_x <= '0;
      s1_tile_y <= '0;
    end else begin
      buf_addr  <= cell_ok ? addr_next : 11'd0;
      s1_valid  <= cell_ok;
      s1_hit    <= cell_ok && cursor_hit;
      s1_tile_x <= pix_x[3:0];
      s1_tile_y <= pix_y[3:0];
    end
  end

  // buf_data arrives one cycle after buf_addr, lining up with the stage-1 flags
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      char       <= '0;
      char_color <= '0;
      back_color <= '0;
      vid_active <= 1'b0;
      tile_x     <= '0;
      tile_y     <= '0;
    end else if (s1_valid) begin
      char       <= buf_data[30:24];
      vid_active <= 1'b1;
      tile_x     <= s1_tile_x;
      tile_y     <= s1_tile_y;
      if (s1_hit && blink_on) begin
        char_color <= buf_data[11:0];
        back_color <= buf_data[23:12];
      end else begin
        char_color <= buf_data[23:12];
        back_color <= buf_data[11:0];
      end
    end else begin
      char       <= '0;
      char_color <= '0;
      back_color <= '0;
      vid_active <= 1'b0;
      tile_x     <= '0;
      tile_y     <= '0;
    end
  end

  assign vsync_fall = vsync_prev && !vsync_in;

  // frame counter and blink phase freeze while fetching is disabled
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev <= 1'b1;
      frame_cnt  <= '0;
      blink_on   <= 1'b1;
    end else begin
      vsync_prev <= vsync_in;
      if (en && vsync_fall) begin
        if (frame_cnt == BLINK_LAST) begin
          frame_cnt <= '0;
          blink_on  <= !blink_on;
        end else begin
          frame_cnt <= frame_cnt + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_sr <= '1;
      vs_sr <= '1;
    end else begin
      hs_sr[0] <= hsync_in;
      vs_sr[0] <= vsync_in;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        hs_sr[i] <= hs_sr[i-1];
        vs_sr[i] <= vs_sr[i-1];
      end
    end
  end

  assign hsync_out = hs_sr[SYNC_DELAY-1];
  assign vsync_out = vs_sr[SYNC_DELAY-1];

endmodule
